// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: steps each instruction through FETCH/DECODE/EXEC and adds the IN
// handshake, a programmable delay and interrupt entry/exit, decoding datapath flags from state.
module multicycle_control_unit #(
  parameter int OPCODE_W     = 6,
  parameter int DELAY_W      = 16,
  parameter int DELAY_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                interruption,
  input  logic                flagJB,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                in_valid,
  output logic                flagDM,
  output logic                flagJR,
  output logic                flagLSR,
  output logic                flagRF,
  output logic                flagOUT,
  output logic [1:0]          flagPC,
  output logic [1:0]          flagBQ,
  output logic [2:0]          flagMuxRF,
  output logic                LED,
  output logic                instr_done,
  output logic                irq_ack,
  output logic                illegal_op,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT_IN = 3'd3,
    S_DELAY   = 3'd4,
    S_HALT    = 3'd5,
    S_IRQ     = 3'd6
  } stateT;

  localparam logic [OPCODE_W-1:0] OP_ALU    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LI     = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LR     = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SR     = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BNQ    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JMP    = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JR     = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_HLT    = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_IN     = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_OUT    = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_DLY    = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_DLYN   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_LIMIT  = OPCODE_W'(16);
  localparam logic [DELAY_W-1:0]  DELAY_LOAD = DELAY_W'(DELAY_CYCLES - 1);

  stateT               r_state;
  logic [OPCODE_W-1:0] r_opcodeQ;
  logic [DELAY_W-1:0]  r_count;
  logic                r_illegalOp;
  logic                w_delayDone;

  assign w_delayDone = (r_count == '0);

  // A finishing delay commits even if an interrupt arrives in that same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_opcodeQ   <= '0;
      r_count     <= '0;
      r_illegalOp <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_opcodeQ <= opcode;
          if (interruption) begin
            r_state <= S_IRQ;
          end else if (opcode >= OP_LIMIT) begin
            r_illegalOp <= 1'b1;
            r_state     <= S_HALT;
          end else if (opcode == OP_IN) begin
            r_state <= S_WAIT_IN;
          end else if (opcode == OP_DLY || opcode == OP_DLYN) begin
            r_count <= DELAY_LOAD;
            r_state <= S_DELAY;
          end else if (opcode == OP_HLT) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: r_state <= S_FETCH;
        S_WAIT_IN: begin
          if (in_valid)          r_state <= S_FETCH;
          else if (interruption) r_state <= S_IRQ;
        end
        S_DELAY: begin
          if (w_delayDone) begin
            r_state <= S_FETCH;
          end else if (interruption) begin
            r_count <= '0;
            r_state <= S_IRQ;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_HALT:  if (interruption)  r_state <= S_IRQ;
        S_IRQ:   if (!interruption) r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Flags are suppressed during reset so an aborted instruction never drives the datapath.
  always_comb begin
    flagDM     = 1'b0;
    flagJR     = 1'b0;
    flagLSR    = 1'b0;
    flagRF     = 1'b0;
    flagOUT    = 1'b0;
    flagPC     = 2'd0;
    flagBQ     = 2'd0;
    flagMuxRF  = 3'd0;
    LED        = 1'b0;
    instr_done = 1'b0;
    irq_ack    = 1'b0;
    illegal_op = r_illegalOp;
    state_o    = r_state;
    if (!reset) begin
      case (r_state)
        S_EXEC: begin
          instr_done = 1'b1;
          case (r_opcodeQ)
            OP_ALU: begin flagRF = 1'b1; flagPC = 2'd1; flagMuxRF = 3'd1; end
            OP_LW:  begin flagRF = 1'b1; flagPC = 2'd1; flagMuxRF = 3'd2; end
            OP_LI:  begin flagRF = 1'b1; flagPC = 2'd1; flagMuxRF = 3'd4; end
            OP_LR:  begin flagLSR = 1'b1; flagRF = 1'b1; flagPC = 2'd1; flagMuxRF = 3'd2; end
            OP_SW:  begin flagDM = 1'b1; flagPC = 2'd1; end
            OP_SR:  begin flagDM = 1'b1; flagLSR = 1'b1; flagPC = 2'd1; end
            OP_BEQ: begin flagBQ = 2'd1; flagPC = flagJB ? 2'd2 : 2'd1; end
            OP_BNQ: begin flagBQ = 2'd2; flagPC = flagJB ? 2'd2 : 2'd1; end
            OP_JMP: flagPC = 2'd2;
            OP_JR:  begin flagJR = 1'b1; flagPC = 2'd2; end
            OP_NOP: flagPC = 2'd1;
            OP_OUT: begin flagOUT = 1'b1; flagPC = 2'd1; end
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          LED     = 1'b1;
          flagOUT = 1'b1;
          if (in_valid) begin
            flagRF     = 1'b1;
            flagMuxRF  = 3'd3;
            flagPC     = 2'd1;
            instr_done = 1'b1;
          end
        end
        S_DELAY: begin
          flagOUT = (r_opcodeQ == OP_DLY);
          if (w_delayDone) begin
            flagPC     = 2'd3;
            instr_done = 1'b1;
          end
        end
        S_HALT:  flagOUT = 1'b1;
        S_IRQ:   irq_ack = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: EXEC vector table, hand-written multi-cycle
// sequences, then randomized stimulus against a cycle-counting reference model.
module tb_multicycle_control_unit;

  localparam int DLY = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       interruption = 1'b0;
  logic       flagJB = 1'b0;
  logic [5:0] opcode = '0;
  logic       in_valid = 1'b0;
  logic       flagDM, flagJR, flagLSR, flagRF, flagOUT;
  logic [1:0] flagPC, flagBQ;
  logic [2:0] flagMuxRF;
  logic       LED, instr_done, irq_ack, illegal_op;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;

  multicycle_control_unit #(.OPCODE_W(6), .DELAY_W(16), .DELAY_CYCLES(DLY)) dut (
    .clock(clock), .reset(reset), .interruption(interruption), .flagJB(flagJB),
    .opcode(opcode), .in_valid(in_valid), .flagDM(flagDM), .flagJR(flagJR),
    .flagLSR(flagLSR), .flagRF(flagRF), .flagOUT(flagOUT), .flagPC(flagPC),
    .flagBQ(flagBQ), .flagMuxRF(flagMuxRF), .LED(LED), .instr_done(instr_done),
    .irq_ack(irq_ack), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] state;
    logic       illegal, ack, done, led;
    logic       dm, jr, lsr, rf, out;
    logic [1:0] pc, bq;
    logic [2:0] mux;
  } expT;

  typedef struct {
    logic [5:0] op;
    logic       jb;
    expT        flags;
  } vecT;

  vecT vecs[$];

  // Model: state numbers as listed in the state encoding table, delay tracked as elapsed cycles.
  int mPhase = 0;
  int mOp = 0;
  int mElapsed = 0;
  bit mIllegal = 0;

  function automatic expT ex(int st, int pc, int out, int led, int done, int ack, int ill);
    expT e = '0;
    e.state = 3'(st);
    e.pc = 2'(pc);
    e.out = (out != 0);
    e.led = (led != 0);
    e.done = (done != 0);
    e.ack = (ack != 0);
    e.illegal = (ill != 0);
    return e;
  endfunction

  function automatic void addVec(int op, int jb, int dm, int jr, int lsr, int rf, int out,
                                 int pc, int bq, int mux);
    vecT v;
    v.op = 6'(op);
    v.jb = (jb != 0);
    v.flags = ex(2, pc, out, 0, 1, 0, 0);
    v.flags.dm = (dm != 0);
    v.flags.jr = (jr != 0);
    v.flags.lsr = (lsr != 0);
    v.flags.rf = (rf != 0);
    v.flags.bq = 2'(bq);
    v.flags.mux = 3'(mux);
    vecs.push_back(v);
  endfunction

  function automatic expT execFlags(int op, logic jb);
    foreach (vecs[i])
      if (int'(vecs[i].op) == op && (vecs[i].jb == jb || (op != 6 && op != 7)))
        return vecs[i].flags;
    return ex(2, 0, 0, 0, 1, 0, 0);
  endfunction

  function automatic expT actualOut();
    expT a;
    a.state = state_o; a.illegal = illegal_op; a.ack = irq_ack; a.done = instr_done;
    a.led = LED; a.dm = flagDM; a.jr = flagJR; a.lsr = flagLSR; a.rf = flagRF;
    a.out = flagOUT; a.pc = flagPC; a.bq = flagBQ; a.mux = flagMuxRF;
    return a;
  endfunction

  task automatic applyStimulus(input int r, input int intr, input int jb, input int op, input int iv);
    @(negedge clock);
    reset = (r != 0);
    interruption = (intr != 0);
    flagJB = (jb != 0);
    opcode = 6'(op);
    in_valid = (iv != 0);
    #1;
  endtask

  task automatic checkOutput(input string name, input expT want);
    expT got;
    got = actualOut();
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic expT modelExpect();
    expT e = ex(mPhase, 0, 0, 0, 0, 0, mIllegal);
    if (reset) return e;
    case (mPhase)
      2: begin e = execFlags(mOp, flagJB); e.illegal = mIllegal; end
      3: begin
        e.led = 1; e.out = 1;
        if (in_valid) begin e.rf = 1; e.mux = 3; e.pc = 1; e.done = 1; end
      end
      4: begin
        e.out = (mOp == 14);
        if (mElapsed == DLY) begin e.pc = 3; e.done = 1; end
      end
      5: e.out = 1;
      6: e.ack = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic modelAdvance();
    if (reset) begin
      mPhase = 0; mOp = 0; mElapsed = 0; mIllegal = 0;
      return;
    end
    case (mPhase)
      0: mPhase = 1;
      1: begin
        mOp = int'(opcode);
        if (interruption) mPhase = 6;
        else if (mOp >= 16) begin mIllegal = 1; mPhase = 5; end
        else if (mOp == 12) mPhase = 3;
        else if (mOp == 14 || mOp == 15) begin mPhase = 4; mElapsed = 1; end
        else if (mOp == 11) mPhase = 5;
        else mPhase = 2;
      end
      2: mPhase = 0;
      3: if (in_valid) mPhase = 0; else if (interruption) mPhase = 6;
      4: if (mElapsed == DLY) mPhase = 0; else if (interruption) mPhase = 6; else mElapsed++;
      5: if (interruption) mPhase = 6;
      6: if (!interruption) mPhase = 0;
      default: mPhase = 0;
    endcase
  endtask

  initial begin
    expT e;
    //     op jb dm jr lsr rf out pc bq mux
    addVec(0,  0, 0, 0, 0,  1, 0,  1, 0, 1);
    addVec(1,  1, 0, 0, 0,  1, 0,  1, 0, 2);
    addVec(2,  0, 0, 0, 0,  1, 0,  1, 0, 4);
    addVec(3,  1, 0, 0, 1,  1, 0,  1, 0, 2);
    addVec(4,  0, 1, 0, 0,  0, 0,  1, 0, 0);
    addVec(5,  1, 1, 0, 1,  0, 0,  1, 0, 0);
    addVec(6,  1, 0, 0, 0,  0, 0,  2, 1, 0);
    addVec(7,  0, 0, 0, 0,  0, 0,  1, 2, 0);
    addVec(6,  0, 0, 0, 0,  0, 0,  1, 1, 0);
    addVec(7,  1, 0, 0, 0,  0, 0,  2, 2, 0);
    addVec(8,  0, 0, 0, 0,  0, 0,  2, 0, 0);
    addVec(9,  1, 0, 1, 0,  0, 0,  2, 0, 0);
    addVec(10, 0, 0, 0, 0,  0, 0,  1, 0, 0);
    addVec(13, 1, 0, 0, 0,  0, 1,  1, 0, 0);

    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("resetState", ex(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 1, 20, 1);
    checkOutput("resetHold", ex(0, 0, 0, 0, 0, 0, 0));

    // EXEC-class table; opcode is junk outside DECODE to prove it was latched.
    foreach (vecs[i]) begin
      applyStimulus(0, 0, 0, $urandom_range(0, 63), $urandom_range(0, 1));
      checkOutput("vecFetch", ex(0, 0, 0, 0, 0, 0, 0));
      applyStimulus(0, 0, 0, vecs[i].op, 0);
      checkOutput("vecDecode", ex(1, 0, 0, 0, 0, 0, 0));
      applyStimulus(0, 0, vecs[i].jb, $urandom_range(0, 63), $urandom_range(0, 1));
      checkOutput("vecExec", vecs[i].flags);
    end

    // IN with five idle cycles before in_valid.
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("inFetch", ex(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 12, 0); checkOutput("inDecode", ex(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("inWait", ex(3, 0, 1, 1, 0, 0, 0));
    end
    applyStimulus(0, 0, 0, 0, 1);
    e = ex(3, 1, 1, 1, 1, 0, 0); e.rf = 1; e.mux = 3;
    checkOutput("inCommit", e);
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("inBackToFetch", ex(0, 0, 0, 0, 0, 0, 0));

    // DLY_OUT runs the full delay with the display on.
    applyStimulus(0, 0, 0, 14, 0); checkOutput("dlyDecode", ex(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < DLY; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("dlyCount", ex(4, (k == DLY - 1) ? 3 : 0, 1, 0, (k == DLY - 1) ? 1 : 0, 0, 0));
    end
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("dlyBackToFetch", ex(0, 0, 0, 0, 0, 0, 0));

    // DLY_NOT_OUT interrupted in its second delay cycle, then replayed in full.
    applyStimulus(0, 0, 0, 15, 0); checkOutput("irqDecode", ex(1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("irqDelay1", ex(4, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 0, 0, 0);  checkOutput("irqDelay2", ex(4, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 0, 0, 0);  checkOutput("irqHeld", ex(6, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("irqDrop", ex(6, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("irqFetch", ex(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 15, 0); checkOutput("replayDecode", ex(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < DLY; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("replayCount", ex(4, (k == DLY - 1) ? 3 : 0, 0, 0, (k == DLY - 1) ? 1 : 0, 0, 0));
    end

    // Illegal opcode halts sticky until reset.
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("illFetch", ex(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 20, 0); checkOutput("illDecode", ex(1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 1);  checkOutput("illHalt1", ex(5, 0, 1, 0, 0, 0, 1));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("illHalt2", ex(5, 0, 1, 0, 0, 0, 1));
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("illResetCycle", ex(5, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("illCleared", ex(0, 0, 0, 0, 0, 0, 0));

    // Reset in WAIT_IN aborts even with in_valid high.
    applyStimulus(0, 0, 0, 12, 0); checkOutput("abortDecode", ex(1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("abortWait", ex(3, 0, 1, 1, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, 1);  checkOutput("abortResetCycle", ex(3, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("abortFetch", ex(0, 0, 0, 0, 0, 0, 0));

    // Randomized run against the reference model.
    applyStimulus(1, 0, 0, 0, 0);
    modelAdvance();
    for (int n = 0; n < 1500; n++) begin
      int op;
      op = ($urandom_range(0, 31) < 29) ? $urandom_range(0, 15) : $urandom_range(16, 63);
      applyStimulus(($urandom_range(0, 99) == 0) ? 1 : 0,
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    $urandom_range(0, 1), op,
                    ($urandom_range(0, 2) == 0) ? 1 : 0);
      checkOutput("random", modelExpect());
      modelAdvance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control unit for the single-issue processor: sequences each instruction through FETCH, DECODE and EXEC states and drives the datapath flags. It adds three things a purely combinational decoder cannot: a wait-for-input handshake for IN, a programmable delay counter for DLY_OUT/DLY_NOT_OUT, and an interrupt entry/exit protocol. It sits between instruction memory (opcode source) and the datapath muxes, PC logic, register file and data memory.

## Interface
- OPCODE_W, 6, opcode width; opcodes 16 and above are illegal.
- DELAY_W, 16, delay counter width.
- DELAY_CYCLES, 1000, length of the DELAY state in cycles; must be ≥1 and < 2^DELAY_W.

- clock  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- interruption  in  1  interrupt request, level.
- flagJB  in  1  branch-condition result from the ALU.
- opcode  in  OPCODE_W  instruction opcode from instruction memory.
- in_valid  in  1  input-switch data valid (IN handshake).
- flagDM, flagJR, flagLSR, flagRF, flagOUT  out  1 each  data-memory write, jump-register select, register-addressed load/store, register-file write, display enable.
- flagPC  out  2  PC control: 0 hold, 1 increment, 2 jump/branch, 3 delay-complete increment.
- flagBQ  out  2  branch type: 0 none, 1 BEQ, 2 BNQ.
- flagMuxRF  out  3  register-file write source.
- LED  out  1  input-request indicator.
- instr_done  out  1  one-cycle pulse when an instruction commits.
- irq_ack  out  1  high while in IRQ.
- illegal_op  out  1  sticky; cleared only by reset.
- state_o  out  3  current state.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, WAIT_IN=3, DELAY=4, HALT=5, IRQ=6.
- Outputs are Moore outputs decoded from the state and the latched opcode_q. WAIT_IN additionally uses in_valid.
- In every state not listed below, all flags are 0.
- **FETCH**
  - One cycle for the instruction-memory read.
  - Next state: DECODE.
- **DECODE**
  - Latches opcode into opcode_q.
  - Priority order:
    1. interruption=1 → IRQ.
    2. Opcode ≥16 → set illegal_op, go to HALT.
    3. IN (12) → WAIT_IN.
    4. DLY_OUT (14) or DLY_NOT_OUT (15) → load counter with DELAY_CYCLES-1, go to DELAY.
    5. HLT (11) → HALT.
    6. Otherwise → EXEC.
- **EXEC**
  - One cycle; flags are driven from opcode_q:
    - ALU(0): RF=1, PC=1, MuxRF=1.
    - LW(1): RF=1, PC=1, MuxRF=2.
    - LI(2): RF=1, PC=1, MuxRF=4.
    - LR(3): LSR=1, RF=1, PC=1, MuxRF=2.
    - SW(4): DM=1, PC=1.
    - SR(5): DM=1, LSR=1, PC=1.
    - BEQ(6): BQ=1, PC = flagJB ? 2 : 1.
    - BNQ(7): BQ=2, PC = flagJB ? 2 : 1.
    - JMP(8): PC=2.
    - JR(9): JR=1, PC=2.
    - NOP(10): PC=1.
    - OUT(13): OUT=1, PC=1.
  - instr_done=1.
  - interruption is ignored during EXEC.
  - Next state: FETCH.
- **WAIT_IN**
  - LED=1, flagOUT=1.
  - While in_valid=0: all other flags are 0 and the state holds.
  - In the cycle in_valid=1: RF=1, MuxRF=3, PC=1, instr_done=1; next state is FETCH.
  - interruption=1 with in_valid=0 → IRQ with no commit; the instruction replays after IRQ.
  - interruption=1 together with in_valid=1: the commit wins and the IRQ is taken at the next DECODE.
- **DELAY**
  - flagOUT = (opcode_q==14).
  - Counter decrements each cycle; PC=0 while the counter is nonzero.
  - Counter==0: PC=3, instr_done=1; next state is FETCH.
  - interruption=1 → IRQ; the counter is discarded and the instruction replays.
- **HALT**
  - flagOUT=1, PC=0.
  - Exits only to IRQ (on interruption=1) or via reset.
  - The IRQ exit path goes to FETCH, so the halted instruction re-decodes.
- **IRQ**
  - irq_ack=1, all flags 0.
  - Holds while interruption=1; → FETCH when it drops.
  - The PC is never advanced by an aborted instruction.

## Timing
- Reset (synchronous) has priority over all other inputs. After it:
  - state=FETCH.
  - opcode_q=0, counter=0, illegal_op=0.
  - All outputs 0; state_o=0.
- Reset asserted mid-instruction aborts that instruction; no flags are asserted in the reset cycle.
- Instruction latencies:
  - EXEC-class: 3 cycles (FETCH, DECODE, EXEC).
  - IN: 3 cycles plus in_valid wait cycles.
  - DLY: 2 + DELAY_CYCLES cycles.
- flagJB is sampled combinationally during EXEC.
- in_valid is sampled in WAIT_IN only; a pulse in any other state is ignored.
- interruption is sampled in DECODE, WAIT_IN, DELAY, HALT and IRQ; it is ignored in FETCH and EXEC.
- instr_done and PC≠0 occur in the same cycle, at most once per instruction.

## Test plan
- Reset, then ALU opcode 0 → state_o 0,1,2,0; exactly one cycle of RF=1, MuxRF=1, PC=1, instr_done=1.
- BEQ with flagJB=1, then BNQ with flagJB=0 → EXEC cycles show BQ=1, PC=2, then BQ=2, PC=1.
- IN with in_valid raised 5 cycles after entering WAIT_IN → LED=1 for 6 cycles; a single cycle of RF=1, MuxRF=3, PC=1.
- DLY_OUT with DELAY_CYCLES=4 → 4 DELAY cycles with flagOUT=1: PC=0,0,0,3, then FETCH.
- Interruption raised at cycle 2 of a DELAY → IRQ with irq_ack=1 and no PC pulse; interruption drops → FETCH and the DLY replays in full.
- Opcode 20 → illegal_op=1 and HALT with flagOUT=1; reset clears illegal_op to 0.
